regfile_mp: RTL and testbench

Parametrised multi-port register file for the 5-stage pipeline. It has NUM_RD combinational read ports and two write ports (W0 for the EX/MEM result, W1 for the WB result), with write-to-read bypass. A post-reset sweep FSM clears every entry, so contents are deterministic without a reset fan-out to the array. An optional scoreboard tracks registers with outstanding writes.

---
 rtl/regfile_mp.sv | 89 ++++++++
 tb/tb_regfile_mp.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two write ports, write-to-read bypass and a post-reset clear sweep
// Ports: clk; rst (synchronous, active-low); w0_*/w1_* write ports (W1 wins on a shared address);
//   r_en/r_addr/r_data are NUM_RD packed combinational read ports; init_busy is high while the clear sweep runs.
// Optional REGFILE_SCOREBOARD_EN: sb_set_en/sb_set_addr mark registers with outstanding writes, r_pending per read port.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 3,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w0_en,
  input  logic [ADDR_W-1:0]        w0_addr,
  input  logic [DATA_W-1:0]        w0_data,
  input  logic                     w1_en,
  input  logic [ADDR_W-1:0]        w1_addr,
  input  logic [DATA_W-1:0]        w1_data,
  input  logic [NUM_RD-1:0]        r_en,
  input  logic [NUM_RD*ADDR_W-1:0] r_addr,
  output logic [NUM_RD*DATA_W-1:0] r_data,
`ifdef REGFILE_SCOREBOARD_EN
  input  logic                     sb_set_en,
  input  logic [ADDR_W-1:0]        sb_set_addr,
  output logic [NUM_RD-1:0]        r_pending,
`endif
  output logic                     init_busy
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH-1);
  typedef enum logic {INIT, RUN} state_t;
  state_t r_state, w_state_nxt;
  logic [ADDR_W:0] r_clr_cnt, w_clr_nxt;
  logic r_init_busy;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic w_run, w_w0_ok, w_w1_ok;
  assign w_run   = rst && r_state == RUN;
  assign w_w0_ok = w_run && w0_en && !(ZERO_REG != 0 && w0_addr == '0);
  assign w_w1_ok = w_run && w1_en && !(ZERO_REG != 0 && w1_addr == '0);
  assign init_busy = r_init_busy;
  always_comb begin
    w_state_nxt = (r_state == INIT && r_clr_cnt == LAST) ? RUN : r_state;
    w_clr_nxt   = (r_state == INIT) ? r_clr_cnt + (ADDR_W+1)'(1) : r_clr_cnt;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= INIT;
      r_clr_cnt   <= '0;
      r_init_busy <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_clr_cnt   <= w_clr_nxt;
      r_init_busy <= w_state_nxt == INIT;
    end
  end
  // Array has no reset; the sweep clears it one entry per edge instead. W1 is assigned last so it wins.
  always_ff @(posedge clk) begin
    if (rst && r_state == INIT) r_mem[r_clr_cnt[ADDR_W-1:0]] <= '0;
    else begin
      if (w_w0_ok) r_mem[w0_addr] <= w0_data;
      if (w_w1_ok) r_mem[w1_addr] <= w1_data;
    end
  end
`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] r_pend;
  // Clears are applied before the set so a same-edge set on the written address wins.
  always_ff @(posedge clk) begin
    if (!rst || r_state == INIT) r_pend <= '0;
    else begin
      if (w0_en) r_pend[w0_addr] <= 1'b0;
      if (w1_en) r_pend[w1_addr] <= 1'b0;
      if (sb_set_en && !(ZERO_REG != 0 && sb_set_addr == '0)) r_pend[sb_set_addr] <= 1'b1;
    end
  end
`endif
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] w_a;
    logic w_h0, w_h1;
    assign w_a  = r_addr[g*ADDR_W +: ADDR_W];
    assign w_h0 = w0_en && w0_addr == w_a;
    assign w_h1 = w1_en && w1_addr == w_a;
    assign r_data[g*DATA_W +: DATA_W] =
      (init_busy || !r_en[g] || (ZERO_REG != 0 && w_a == '0)) ? '0 :
      w_h1 ? w1_data : w_h0 ? w0_data : r_mem[w_a];
`ifdef REGFILE_SCOREBOARD_EN
    assign r_pending[g] = r_en[g] && r_pend[w_a] && !(w_h0 || w_h1);
`endif
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard-driven bench for regfile_mp (default parameters)
module tb_regfile_mp;
  localparam int DW = 32, AW = 5, NR = 3, DEPTH = 32;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, w0_en, w1_en, init_busy;
  logic [AW-1:0] w0_addr, w1_addr;
  logic [DW-1:0] w0_data, w1_data;
  logic [NR-1:0] r_en;
  logic [NR*AW-1:0] r_addr;
  logic [NR*DW-1:0] r_data;
`ifdef REGFILE_SCOREBOARD_EN
  logic sb_set_en;
  logic [AW-1:0] sb_set_addr;
  logic [NR-1:0] r_pending;
`endif
  int n_tests = 0, n_fail = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got, exp;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst),
    .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data),
    .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data),
    .r_en(r_en), .r_addr(r_addr), .r_data(r_data),
`ifdef REGFILE_SCOREBOARD_EN
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .r_pending(r_pending),
`endif
    .init_busy(init_busy)
  );

  function automatic logic [DW-1:0] rd(input int p);
    return r_data[p*DW +: DW];
  endfunction

  task automatic set_rd(input int p, input logic [AW-1:0] a, input logic en);
    r_addr[p*AW +: AW] = a;
    r_en[p] = en;
  endtask

  task automatic test_reset;
    rst = 1'b0; w0_en = 1'b0; w1_en = 1'b0;
    w0_addr = '0; w1_addr = '0; w0_data = '0; w1_data = '0;
`ifdef REGFILE_SCOREBOARD_EN
    sb_set_en = 1'b0; sb_set_addr = '0;
`endif
    for (int p = 0; p < NR; p++) set_rd(p, 5'd9, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(32'd1);
    exp = exp_q.pop_front(); got = {31'b0, init_busy}; n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_busy: got %0h want %0h", got, exp); end
    // Writes driven during the sweep must be ignored.
    @(negedge clk);
    rst = 1'b1;
    w0_en = 1'b1; w0_addr = 5'd2; w0_data = 32'hBAD0BAD0;
    w1_en = 1'b1; w1_addr = 5'd3; w1_data = 32'hBAD1BAD1;
    for (int k = 1; k <= DEPTH; k++) begin
      @(posedge clk);
      #1;
      exp_q.push_back((k < DEPTH) ? 32'd1 : 32'd0);
      exp_q.push_back(32'd0);
      exp = exp_q.pop_front(); got = {31'b0, init_busy}; n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL sweep_busy edge %0d: got %0h want %0h", k, got, exp); end
      exp = exp_q.pop_front(); got = rd(0); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL sweep_read edge %0d: got %h want %h", k, got, exp); end
    end
    w0_en = 1'b0; w1_en = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      for (int p = 0; p < NR; p++) begin set_rd(p, AW'(a), 1'b1); exp_q.push_back('0); end
      #1;
      for (int p = 0; p < NR; p++) begin
        exp = exp_q.pop_front(); got = rd(p); n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL cleared a%0d p%0d: got %h want %h", a, p, got, exp); end
      end
    end
  endtask

  task automatic test_bypass;
    @(negedge clk);
    w0_en = 1'b1; w0_addr = 5'd5; w0_data = 32'hDEADBEEF;
    set_rd(0, 5'd5, 1'b1);
    exp_q.push_back(32'hDEADBEEF);
    #1;
    exp = exp_q.pop_front(); got = rd(0); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL bypass_w0: got %h want %h", got, exp); end
    @(posedge clk);
    #1;
    w0_en = 1'b0;
    exp_q.push_back(32'hDEADBEEF);
    #1;
    exp = exp_q.pop_front(); got = rd(0); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL array_r5: got %h want %h", got, exp); end
    @(negedge clk);
    w1_en = 1'b1; w1_addr = 5'd8; w1_data = 32'h33333333;
    set_rd(0, 5'd8, 1'b1);
    exp_q.push_back(32'h33333333);
    #1;
    exp = exp_q.pop_front(); got = rd(0); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL bypass_w1: got %h want %h", got, exp); end
    @(posedge clk);
    #1;
    w1_en = 1'b0;
  endtask

  task automatic test_collision;
    @(negedge clk);
    w0_en = 1'b1; w0_addr = 5'd7; w0_data = 32'h11111111;
    w1_en = 1'b1; w1_addr = 5'd7; w1_data = 32'h22222222;
    set_rd(1, 5'd7, 1'b1);
    exp_q.push_back(32'h22222222);
    #1;
    exp = exp_q.pop_front(); got = rd(1); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL collide_bypass: got %h want %h", got, exp); end
    @(posedge clk);
    #1;
    w0_en = 1'b0; w1_en = 1'b0;
    exp_q.push_back(32'h22222222);
    #1;
    exp = exp_q.pop_front(); got = rd(1); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL collide_array: got %h want %h", got, exp); end
  endtask

  task automatic test_zero_reg;
    @(negedge clk);
    w0_en = 1'b1; w0_addr = 5'd0; w0_data = 32'hFFFFFFFF;
    w1_en = 1'b1; w1_addr = 5'd0; w1_data = 32'hFFFFFFFF;
    for (int p = 0; p < NR; p++) begin set_rd(p, 5'd0, 1'b1); exp_q.push_back('0); end
    #1;
    for (int p = 0; p < NR; p++) begin
      exp = exp_q.pop_front(); got = rd(p); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL r0_during p%0d: got %h want %h", p, got, exp); end
    end
    @(posedge clk);
    #1;
    w0_en = 1'b0; w1_en = 1'b0;
    for (int p = 0; p < NR; p++) exp_q.push_back('0);
    #1;
    for (int p = 0; p < NR; p++) begin
      exp = exp_q.pop_front(); got = rd(p); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL r0_after p%0d: got %h want %h", p, got, exp); end
    end
    for (int p = 0; p < NR; p++) set_rd(p, 5'd5, p != 2);
    exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'hDEADBEEF); exp_q.push_back('0);
    #1;
    for (int p = 0; p < NR; p++) begin
      exp = exp_q.pop_front(); got = rd(p); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL r_en_gate p%0d: got %h want %h", p, got, exp); end
    end
  endtask

  task automatic test_independent;
    set_rd(0, 5'd5, 1'b1); set_rd(1, 5'd7, 1'b1); set_rd(2, 5'd8, 1'b1);
    exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'h22222222); exp_q.push_back(32'h33333333);
    #1;
    for (int p = 0; p < NR; p++) begin
      exp = exp_q.pop_front(); got = rd(p); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL indep p%0d: got %h want %h", p, got, exp); end
    end
  endtask

`ifdef REGFILE_SCOREBOARD_EN
  task automatic test_scoreboard;
    @(negedge clk);
    sb_set_en = 1'b1; sb_set_addr = 5'd9;
    set_rd(0, 5'd9, 1'b1); set_rd(1, 5'd4, 1'b1);
    @(posedge clk);
    #1;
    sb_set_en = 1'b0;
    exp_q.push_back(32'd1);
    #1;
    exp = exp_q.pop_front(); got = {31'b0, r_pending[0]}; n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL pend_set_r9: got %0h want %0h", got, exp); end
    @(negedge clk);
    w1_en = 1'b1; w1_addr = 5'd9; w1_data = 32'h99999999;
    exp_q.push_back(32'd0);
    #1;
    exp = exp_q.pop_front(); got = {31'b0, r_pending[0]}; n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL pend_bypass_r9: got %0h want %0h", got, exp); end
    @(posedge clk);
    #1;
    w1_en = 1'b0;
    exp_q.push_back(32'd0);
    #1;
    exp = exp_q.pop_front(); got = {31'b0, r_pending[0]}; n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL pend_clear_r9: got %0h want %0h", got, exp); end
    @(negedge clk);
    sb_set_en = 1'b1; sb_set_addr = 5'd4;
    w0_en = 1'b1; w0_addr = 5'd4; w0_data = 32'h44444444;
    @(posedge clk);
    #1;
    sb_set_en = 1'b0; w0_en = 1'b0;
    exp_q.push_back(32'd1);
    #1;
    exp = exp_q.pop_front(); got = {31'b0, r_pending[1]}; n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL pend_set_wins_r4: got %0h want %0h", got, exp); end
    set_rd(1, 5'd4, 1'b0);
    exp_q.push_back(32'd0);
    #1;
    exp = exp_q.pop_front(); got = {31'b0, r_pending[1]}; n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL pend_ren_gate: got %0h want %0h", got, exp); end
    set_rd(1, 5'd4, 1'b1);
    @(negedge clk);
    sb_set_en = 1'b1; sb_set_addr = 5'd0;
    set_rd(2, 5'd0, 1'b1);
    @(posedge clk);
    #1;
    sb_set_en = 1'b0;
    exp_q.push_back(32'd0);
    #1;
    exp = exp_q.pop_front(); got = {31'b0, r_pending[2]}; n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL pend_r0: got %0h want %0h", got, exp); end
  endtask
`endif

  task automatic test_reset_mid;
    @(negedge clk);
    w0_en = 1'b1; w0_addr = 5'd3; w0_data = 32'hA5A5A5A5;
    w1_en = 1'b1; w1_addr = 5'd20; w1_data = 32'h5A5A5A5A;
    set_rd(0, 5'd3, 1'b1); set_rd(1, 5'd20, 1'b1);
    @(posedge clk);
    #1;
    w0_en = 1'b0; w1_en = 1'b0;
    exp_q.push_back(32'hA5A5A5A5); exp_q.push_back(32'h5A5A5A5A);
    #1;
    for (int p = 0; p < 2; p++) begin
      exp = exp_q.pop_front(); got = rd(p); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL prereset p%0d: got %h want %h", p, got, exp); end
    end
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    exp_q.push_back(32'd1);
    exp = exp_q.pop_front(); got = {31'b0, init_busy}; n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL mid_busy: got %0h want %0h", got, exp); end
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    for (int k = 1; k <= DEPTH; k++) begin
      @(posedge clk);
      #1;
      exp_q.push_back((k < DEPTH) ? 32'd1 : 32'd0);
      exp = exp_q.pop_front(); got = {31'b0, init_busy}; n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL restart_busy edge %0d: got %0h want %0h", k, got, exp); end
    end
    exp_q.push_back('0); exp_q.push_back('0);
    #1;
    for (int p = 0; p < 2; p++) begin
      exp = exp_q.pop_front(); got = rd(p); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL postreset p%0d: got %h want %h", p, got, exp); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_bypass();
    test_collision();
    test_zero_reg();
    test_independent();
`ifdef REGFILE_SCOREBOARD_EN
    test_scoreboard();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
